// File: rtl/collider_stream_tx.sv
// Output serializer for the LBM collider: captures one cell's populations (and
// optionally rho/u_x/u_y) in a single handshake, then streams them as 16-bit AXI4-Stream words.
module collider_stream_tx #(
    parameter bit SEND_MACRO = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [143:0] in_f,
    input  logic [15:0]  in_rho,
    input  logic [15:0]  in_ux,
    input  logic [15:0]  in_uy,
    output logic [15:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic         busy,
    output logic [15:0]  cell_count
);

    localparam int         N        = SEND_MACRO ? 12 : 9;
    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_last;
    logic        capture;
    logic [15:0] pop_q [9];
    logic [15:0] mac_word;
    logic [15:0] sel_word;

    // in_ready reaches back combinationally from tready so a new cell can be
    // taken on the same edge that retires the last word (no bubble).
    assign is_last  = (state_q == S_SEND) && (idx_q == LAST_IDX);
    assign in_ready = (state_q == S_IDLE) || (is_last && m_axis_tready);
    assign capture  = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments only; all next-state
    // logic lives in the always_comb below with defaults assigned first, so no latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_SEND;
                    idx_d   = 4'd0;
                end
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    if (is_last) begin
                        cnt_d   = cnt_q + 16'd1;
                        idx_d   = 4'd0;
                        state_d = in_valid ? S_SEND : S_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // NOTE: the capture registers are pure datapath with no reset; tdata is
    // gated to zero outside SEND, so their power-up contents are never visible.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < 9; i++) begin
                pop_q[i] <= in_f[16*i +: 16];
            end
        end
    end

    if (SEND_MACRO) begin : g_macro
        logic [15:0] mac_q [3];

        always_ff @(posedge clk) begin
            if (capture) begin
                mac_q[0] <= in_rho;
                mac_q[1] <= in_ux;
                mac_q[2] <= in_uy;
            end
        end

        always_comb begin
            case (idx_q)
                4'd9:    mac_word = mac_q[0];
                4'd10:   mac_word = mac_q[1];
                default: mac_word = mac_q[2];
            endcase
        end
    end else begin : g_pop_only
        logic unused_macro;
        assign unused_macro = ^{in_rho, in_ux, in_uy};
        assign mac_word     = 16'd0;
    end

    assign sel_word      = (idx_q < 4'd9) ? pop_q[idx_q] : mac_word;
    assign m_axis_tdata  = (state_q == S_SEND) ? sel_word : 16'd0;
    assign m_axis_tvalid = (state_q == S_SEND);
    assign m_axis_tlast  = is_last;
    assign busy          = (state_q == S_SEND);
    assign cell_count    = cnt_q;

endmodule

// File: tb/tb_collider_stream_tx.sv
// Randomized bench for collider_stream_tx: a word-queue model predicts every
// output each cycle; a second instance covers the population-only build.
module tb_collider_stream_tx;

    typedef logic [15:0] cell_t [12];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [143:0] in_f = '0;
    logic [15:0]  in_rho = '0, in_ux = '0, in_uy = '0;
    logic [15:0]  tdata, cell_count;
    logic         tvalid, tready = 1'b0, tlast, busy;

    logic         v9_valid = 1'b0, v9_ready;
    logic [143:0] v9_f = '0;
    logic [15:0]  v9_rho = '0, v9_ux = '0, v9_uy = '0;
    logic [15:0]  v9_tdata, v9_count;
    logic         v9_tvalid, v9_tready = 1'b0, v9_tlast, v9_busy;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] count_exp = 16'd0;

    always #5 clk = ~clk;

    collider_stream_tx #(.SEND_MACRO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_f(in_f), .in_rho(in_rho), .in_ux(in_ux), .in_uy(in_uy),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .busy(busy), .cell_count(cell_count)
    );

    collider_stream_tx #(.SEND_MACRO(1'b0)) dut9 (
        .clk(clk), .rst_n(rst_n), .in_valid(v9_valid), .in_ready(v9_ready),
        .in_f(v9_f), .in_rho(v9_rho), .in_ux(v9_ux), .in_uy(v9_uy),
        .m_axis_tdata(v9_tdata), .m_axis_tvalid(v9_tvalid), .m_axis_tready(v9_tready),
        .m_axis_tlast(v9_tlast), .busy(v9_busy), .cell_count(v9_count)
    );

    function automatic cell_t rand_cell();
        cell_t c;
        for (int i = 0; i < 12; i++) begin
            c[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
        end
        return c;
    endfunction

    task automatic load_cell(input cell_t c);
        for (int i = 0; i < 9; i++) in_f[16*i +: 16] = c[i];
        in_rho = c[9];
        in_ux  = c[10];
        in_uy  = c[11];
    endtask

    // Per-cycle model: exp_q holds the remaining words of the packet in flight.
    task automatic run_cells(input int ncells, input bit rand_ready,
                             output int beats, output int ir_pulses, output int gaps);
        cell_t       cur;
        int          sent = 0;
        int          cyc = 0;
        bit          exp_ir;
        bit          stalled = 1'b0;
        logic [15:0] held = '0;
        logic        hlast = 1'b0;
        beats = 0; ir_pulses = 0; gaps = 0;
        cur = rand_cell();
        while ((sent < ncells || exp_q.size() != 0) && cyc < 3000) begin
            tready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = (sent < ncells);
            load_cell(cur);
            #1;
            exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && tready);
            total++;
            if (tvalid !== (exp_q.size() != 0)) begin
                bad++; $display("FAIL tvalid cyc=%0d got=%b want=%b", cyc, tvalid, exp_q.size() != 0);
            end
            total++;
            if (in_ready !== exp_ir) begin
                bad++; $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_ir);
            end
            total++;
            if (busy !== (exp_q.size() != 0)) begin
                bad++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                total++;
                if (tdata !== exp_q[0]) begin
                    bad++; $display("FAIL tdata cyc=%0d got=%h want=%h", cyc, tdata, exp_q[0]);
                end
                total++;
                if (tlast !== (exp_q.size() == 1)) begin
                    bad++; $display("FAIL tlast cyc=%0d got=%b want=%b", cyc, tlast, exp_q.size() == 1);
                end
                if (stalled) begin
                    total++;
                    if (tdata !== held || tlast !== hlast) begin
                        bad++; $display("FAIL stall_hold cyc=%0d got=%h/%b want=%h/%b", cyc, tdata, tlast, held, hlast);
                    end
                end
            end
            if (beats > 0 && tvalid !== 1'b1 && (sent < ncells || exp_q.size() != 0)) gaps++;
            if (tvalid === 1'b1 && in_ready === 1'b1) ir_pulses++;
            stalled = (exp_q.size() != 0) && !tready;
            held    = tdata;
            hlast   = tlast;
            if (exp_q.size() != 0 && tready) begin
                beats++;
                if (exp_q.size() == 1) count_exp++;
                void'(exp_q.pop_front());
            end
            if (in_valid && exp_ir) begin
                for (int i = 0; i < 12; i++) exp_q.push_back(cur[i]);
                sent++;
                cur = rand_cell();
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 3000) begin
            total++; bad++;
            $display("FAIL timeout run_cells got=%0d cycles want<3000", cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; tready = 1'b0; v9_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({tvalid, tlast, busy, tdata, cell_count} !== 35'd0) begin
            bad++; $display("FAIL reset_outputs got=%b/%b/%b/%h/%h want=0", tvalid, tlast, busy, tdata, cell_count);
        end
        total++;
        if ({v9_tvalid, v9_tlast, v9_busy, v9_tdata, v9_count} !== 35'd0) begin
            bad++; $display("FAIL reset_outputs9 got=%b/%b/%b/%h/%h want=0", v9_tvalid, v9_tlast, v9_busy, v9_tdata, v9_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || v9_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b/%b want=1/1", in_ready, v9_ready);
        end
        @(negedge clk);
        count_exp = 16'd0;
    endtask

    task automatic test_single();
        cell_t w;
        int    k = 0;
        w = '{16'h0E39, 16'h038E, 16'h00E4, 16'h038E, 16'h00E4, 16'h038E,
              16'h00E4, 16'h038E, 16'h00E4, 16'h2000, 16'h0100, 16'hFF00};
        tready = 1'b1;
        load_cell(w);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        load_cell(rand_cell());
        for (int cyc = 0; cyc < 20 && k < 12; cyc++) begin
            #1;
            if (tvalid === 1'b1) begin
                total++;
                if (tdata !== w[k] || tlast !== (k == 11)) begin
                    bad++; $display("FAIL single_word%0d got=%h/%b want=%h/%b", k, tdata, tlast, w[k], k == 11);
                end
                k++;
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (k !== 12) begin bad++; $display("FAIL single_beats got=%0d want=12", k); end
        total++;
        if (cell_count !== 16'd1 || busy !== 1'b0 || tvalid !== 1'b0) begin
            bad++; $display("FAIL single_end got=%h/%b/%b want=0001/0/0", cell_count, busy, tvalid);
        end
        count_exp = 16'd1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int beats, pulses, gaps;
        run_cells(3, 1'b0, beats, pulses, gaps);
        total++;
        if (beats !== 36 || gaps !== 0) begin
            bad++; $display("FAIL b2b_beats got=%0d gaps=%0d want=36 gaps=0", beats, gaps);
        end
        total++;
        if (pulses !== 3) begin bad++; $display("FAIL b2b_in_ready_pulses got=%0d want=3", pulses); end
        total++;
        if (cell_count !== count_exp) begin
            bad++; $display("FAIL b2b_count got=%h want=%h", cell_count, count_exp);
        end
    endtask

    task automatic test_backpressure();
        int beats, pulses, gaps;
        run_cells(4, 1'b1, beats, pulses, gaps);
        total++;
        if (beats !== 48) begin bad++; $display("FAIL bp_beats got=%0d want=48", beats); end
        total++;
        if (cell_count !== count_exp) begin
            bad++; $display("FAIL bp_count got=%h want=%h", cell_count, count_exp);
        end
    endtask

    task automatic test_no_macro();
        cell_t w;
        int    k = 0;
        bit    rho_seen = 1'b0;
        w = rand_cell();
        for (int i = 0; i < 8; i++) if (w[i] == 16'h1234) w[i] = 16'h4321;
        w[8] = 16'h8000;
        w[9] = 16'h1234;
        for (int i = 0; i < 9; i++) v9_f[16*i +: 16] = w[i];
        v9_rho = w[9]; v9_ux = w[10]; v9_uy = w[11];
        v9_tready = 1'b1;
        v9_valid  = 1'b1;
        @(negedge clk);
        v9_valid = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (v9_tvalid === 1'b1) begin
                if (v9_tdata === 16'h1234) rho_seen = 1'b1;
                if (k < 9) begin
                    total++;
                    if (v9_tdata !== w[k] || v9_tlast !== (k == 8)) begin
                        bad++; $display("FAIL nomacro_word%0d got=%h/%b want=%h/%b", k, v9_tdata, v9_tlast, w[k], k == 8);
                    end
                end
                k++;
            end
            @(negedge clk);
        end
        total++;
        if (k !== 9 || rho_seen) begin
            bad++; $display("FAIL nomacro_beats got=%0d rho_seen=%b want=9 rho_seen=0", k, rho_seen);
        end
        total++;
        if (v9_count !== 16'd1) begin bad++; $display("FAIL nomacro_count got=%h want=0001", v9_count); end
    endtask

    task automatic test_mid_reset();
        cell_t w;
        int    beats, pulses, gaps;
        w = rand_cell();
        tready = 1'b1;
        load_cell(w);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (tvalid !== 1'b1 || tdata !== w[5]) begin
            bad++; $display("FAIL midrst_pre got=%b/%h want=1/%h", tvalid, tdata, w[5]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({tvalid, tlast, busy, tdata, cell_count} !== 35'd0) begin
            bad++; $display("FAIL midrst_outputs got=%b/%b/%b/%h/%h want=0", tvalid, tlast, busy, tdata, cell_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        count_exp = 16'd0;
        #1;
        total++;
        if (tvalid !== 1'b0 || cell_count !== 16'd0) begin
            bad++; $display("FAIL midrst_post got=%b/%h want=0/0000", tvalid, cell_count);
        end
        @(negedge clk);
        run_cells(1, 1'b0, beats, pulses, gaps);
        total++;
        if (cell_count !== 16'd1) begin bad++; $display("FAIL midrst_count got=%h want=0001", cell_count); end
    endtask

    task automatic test_wrap();
        int beats, pulses, gaps;
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_q;
        #1;
        total++;
        if (cell_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffff", cell_count); end
        count_exp = 16'hFFFF;
        @(negedge clk);
        run_cells(1, 1'b0, beats, pulses, gaps);
        total++;
        if (cell_count !== 16'h0000 || count_exp !== 16'h0000) begin
            bad++; $display("FAIL wrap_count got=%h want=0000", cell_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_no_macro();
        test_mid_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
